// File: rtl/fifo_burst_rd_ctrl_if.sv
// Bus bundle between the burst read scheduler, the FIFO read port and the downstream consumer.
// The master modport is the scheduler's view.
interface fifo_burst_rd_ctrl_if #(
   parameter int DATA_W  = 16,
   parameter int USEDW_W = 9
);
   logic               enable;
   logic [USEDW_W-1:0] fifo_rd_usedw;
   logic               fifo_rd_full;
   logic               fifo_rd_empty;
   logic [DATA_W-1:0]  fifo_rd_data;
   logic               fifo_rd_req;
   logic [DATA_W-1:0]  dout;
   logic               dout_valid;
   logic               burst_start;
   logic               burst_done;
   logic               busy;
   logic [15:0]        burst_cnt;

   modport master (
      input  enable, fifo_rd_usedw, fifo_rd_full, fifo_rd_empty, fifo_rd_data,
      output fifo_rd_req, dout, dout_valid, burst_start, burst_done, busy, burst_cnt
   );

   modport slave (
      output enable, fifo_rd_usedw, fifo_rd_full, fifo_rd_empty, fifo_rd_data,
      input  fifo_rd_req, dout, dout_valid, burst_start, burst_done, busy, burst_cnt
   );
endinterface

// File: rtl/fifo_burst_rd_ctrl.sv
// Read-side burst scheduler: waits for a full burst in the FIFO, issues BURST_LEN reads,
// re-registers the returned words and then enforces an idle gap before the next burst.
module fifo_burst_rd_ctrl #(
   parameter int DATA_W    = 16,
   parameter int USEDW_W   = 9,
   parameter int BURST_LEN = 32,
   parameter int GAP_CYC   = 4
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   fifo_burst_rd_ctrl_if.master bus
);
   localparam logic [7:0] RD_LAST  = 8'(BURST_LEN - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        rd_cnt_q, rd_cnt_d;
   logic [7:0]        gap_cnt_q, gap_cnt_d;
   logic              flush_q, flush_d;
   logic              req_d1_q, req_d1_d;
   logic              last_d1_q, last_d1_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic              burst_start_q, burst_start_d;
   logic              burst_done_q, burst_done_d;
   logic              busy_q, busy_d;
   logic [15:0]       burst_cnt_q, burst_cnt_d;

   logic              req_s;
   logic              last_req_s;
   logic              start_ok_s;
   logic [31:0]       usedw_ext_s;

   // Full flag also qualifies because usedw wraps to zero when the FIFO is completely full.
   assign usedw_ext_s = 32'(bus.fifo_rd_usedw);
   assign start_ok_s  = bus.enable && !bus.fifo_rd_empty &&
                        ((usedw_ext_s >= 32'(BURST_LEN)) || bus.fifo_rd_full);

   // Next-state, request generation and output-pipeline logic.
   always_comb begin
      state_d       = state_q;
      rd_cnt_d      = rd_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      flush_d       = flush_q;
      burst_start_d = 1'b0;
      req_s         = 1'b0;
      last_req_s    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_ok_s) begin
               state_d       = ST_READ;
               rd_cnt_d      = 8'd0;
               burst_start_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            // Request straight from empty so the FIFO can never be read while empty.
            req_s = !bus.fifo_rd_empty;
            if (req_s) begin
               if (rd_cnt_q == RD_LAST) begin
                  last_req_s = 1'b1;
                  rd_cnt_d   = 8'd0;
                  flush_d    = 1'b0;
                  state_d    = ST_FLUSH;
               end else begin
                  rd_cnt_d = rd_cnt_q + 8'd1;
               end
            end else begin
               rd_cnt_d = rd_cnt_q;
            end
         end
         ST_FLUSH: begin
            if (flush_q) begin
               flush_d   = 1'b0;
               gap_cnt_d = 8'd0;
               state_d   = ST_GAP;
            end else begin
               flush_d = 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               gap_cnt_d = 8'd0;
               state_d   = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            rd_cnt_d  = 8'd0;
            gap_cnt_d = 8'd0;
            flush_d   = 1'b0;
         end
      endcase

      req_d1_d     = req_s;
      last_d1_d    = last_req_s;
      dout_valid_d = req_d1_q;
      burst_done_d = last_d1_q;
      busy_d       = (state_d != ST_IDLE);

      if (req_d1_q) begin
         dout_d = bus.fifo_rd_data;
      end else begin
         dout_d = dout_q;
      end

      if (last_d1_q) begin
         burst_cnt_d = burst_cnt_q + 16'd1;
      end else begin
         burst_cnt_d = burst_cnt_q;
      end
   end

   // State and output registers; reset aborts any burst and drops in-flight words.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q       <= ST_IDLE;
         rd_cnt_q      <= 8'd0;
         gap_cnt_q     <= 8'd0;
         flush_q       <= 1'b0;
         req_d1_q      <= 1'b0;
         last_d1_q     <= 1'b0;
         dout_q        <= '0;
         dout_valid_q  <= 1'b0;
         burst_start_q <= 1'b0;
         burst_done_q  <= 1'b0;
         busy_q        <= 1'b0;
         burst_cnt_q   <= 16'd0;
      end else begin
         state_q       <= state_d;
         rd_cnt_q      <= rd_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         flush_q       <= flush_d;
         req_d1_q      <= req_d1_d;
         last_d1_q     <= last_d1_d;
         dout_q        <= dout_d;
         dout_valid_q  <= dout_valid_d;
         burst_start_q <= burst_start_d;
         burst_done_q  <= burst_done_d;
         busy_q        <= busy_d;
         burst_cnt_q   <= burst_cnt_d;
      end
   end

   assign bus.fifo_rd_req = req_s;
   assign bus.dout        = dout_q;
   assign bus.dout_valid  = dout_valid_q;
   assign bus.burst_start = burst_start_q;
   assign bus.burst_done  = burst_done_q;
   assign bus.busy        = busy_q;
   assign bus.burst_cnt   = burst_cnt_q;
endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Bench for fifo_burst_rd_ctrl: a queue-based FIFO feeds random words, and a burst-level
// scoreboard checks order, latency, burst framing, busy span and spacing.
module tb_fifo_burst_rd_ctrl;
   localparam int DATA_W     = 16;
   localparam int USEDW_W    = 9;
   localparam int BURST_LEN  = 32;
   localparam int GAP_CYC    = 4;
   localparam int FIFO_DEPTH = 512;
   localparam int SPACING    = BURST_LEN + 2 + GAP_CYC + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   int vectors     = 0;
   int miscompares = 0;

   logic [DATA_W-1:0] fifo_q[$];
   logic [DATA_W-1:0] exp_q[$];
   int                start_q[$];
   int                cyc, reqs_in_burst, vals_in_burst, total_reqs, total_valids;
   int                last_req_cyc, gap_left;
   logic              active, req_h1, req_h2, last_req, stall;
   logic [15:0]       exp_burst_cnt;

   fifo_burst_rd_ctrl_if #(.DATA_W(DATA_W), .USEDW_W(USEDW_W)) bus ();

   fifo_burst_rd_ctrl #(
      .DATA_W(DATA_W), .USEDW_W(USEDW_W), .BURST_LEN(BURST_LEN), .GAP_CYC(GAP_CYC)
   ) dut (
      .sys_clk  (clk),
      .sys_rst_n(rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void drive_inputs();
      bus.fifo_rd_usedw = 9'(fifo_q.size());
      bus.fifo_rd_full  = (fifo_q.size() >= FIFO_DEPTH);
      bus.fifo_rd_empty = (fifo_q.size() == 0) || stall;
   endfunction

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(16'($urandom));
      drive_inputs();
   endtask

   task automatic model_reset();
      exp_q.delete();
      reqs_in_burst = 0;
      vals_in_burst = 0;
      active        = 1'b0;
      gap_left      = 0;
      req_h1        = 1'b0;
      req_h2        = 1'b0;
      exp_burst_cnt = 16'd0;
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_flags"}, 32'({bus.fifo_rd_req, bus.dout_valid, bus.burst_start,
                               bus.burst_done, bus.busy}), 32'd0);
      chk({tag, "_dout"}, 32'(bus.dout), 32'd0);
      chk({tag, "_cnt"}, 32'(bus.burst_cnt), 32'd0);
   endtask

   // One clock: score outputs on the falling edge, then act as the FIFO on the rising edge.
   task automatic cycle();
      logic              req_s, exp_start, exp_done, exp_busy;
      logic [DATA_W-1:0] w;
      @(negedge clk);
      cyc++;
      req_s    = bus.fifo_rd_req;
      last_req = req_s;
      chk("no_underflow", 32'(req_s & bus.fifo_rd_empty), 32'd0);
      chk("valid_latency", 32'(bus.dout_valid), 32'(req_h2));
      req_h2 = req_h1;
      req_h1 = req_s;

      exp_start = req_s && (reqs_in_burst == 0);
      chk("burst_start", 32'(bus.burst_start), 32'(exp_start));
      if (exp_start) begin
         active = 1'b1;
         start_q.push_back(cyc);
      end
      if (req_s) begin
         total_reqs++;
         last_req_cyc  = cyc;
         reqs_in_burst = (reqs_in_burst == BURST_LEN - 1) ? 0 : reqs_in_burst + 1;
      end

      exp_done = 1'b0;
      if (bus.dout_valid === 1'b1) begin
         total_valids++;
         chk("pending_word", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) chk("dout", 32'(bus.dout), 32'(exp_q.pop_front()));
         vals_in_burst++;
         if (vals_in_burst == BURST_LEN) begin
            exp_done      = 1'b1;
            vals_in_burst = 0;
            exp_burst_cnt = exp_burst_cnt + 16'd1;
         end
      end
      chk("burst_done", 32'(bus.burst_done), 32'(exp_done));
      chk("burst_cnt", 32'(bus.burst_cnt), 32'(exp_burst_cnt));

      exp_busy = active || (gap_left > 0);
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      if (gap_left > 0) gap_left--;
      if (exp_done) begin
         active   = 1'b0;
         gap_left = GAP_CYC;
      end

      @(posedge clk);
      w = 16'($urandom);
      if (req_s && fifo_q.size() > 0) begin
         w = fifo_q.pop_front();
         exp_q.push_back(w);
      end
      #1;
      bus.fifo_rd_data = w;
      drive_inputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_start(input string tag, input int budget);
      int n0;
      int k;
      n0 = start_q.size();
      k  = 0;
      while (start_q.size() == n0 && k < budget) begin
         cycle();
         k++;
      end
      chk(tag, 32'(start_q.size() - n0), 32'd1);
   endtask

   initial begin
      int r0, v0, n0, k, cnt;
      cyc = 0; total_reqs = 0; total_valids = 0; last_req_cyc = 0;
      stall = 1'b0; last_req = 1'b0;
      model_reset();
      bus.enable       = 1'b0;
      bus.fifo_rd_data = 16'd0;
      drive_inputs();

      // Reset held with plenty of data and enable high: nothing may move.
      #1 rst_n = 1'b0;
      push_words(100);
      bus.enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk_cleared("reset_hold");
      end
      bus.enable = 1'b0;
      rst_n = 1'b1;
      fifo_q.delete();
      drive_inputs();
      run(3);

      // Nominal burst from 40 queued words.
      push_words(40);
      r0 = total_reqs; v0 = total_valids;
      bus.enable = 1'b1;
      wait_start("nominal_start", 3);
      run(60);
      chk("nominal_reqs", 32'(total_reqs - r0), 32'd32);
      chk("nominal_contig", 32'(last_req_cyc - start_q[$]), 32'(BURST_LEN - 1));
      chk("nominal_valids", 32'(total_valids - v0), 32'd32);
      chk("nominal_cnt", 32'(bus.burst_cnt), 32'd1);

      // One word short of a burst: must stay idle, then start once the threshold is met.
      push_words(23);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         cycle();
         if (last_req) cnt++;
      end
      chk("below_thresh_reqs", 32'(cnt), 32'd0);
      push_words(1);
      wait_start("thresh_start", 2);
      run(45);
      chk("thresh_cnt", 32'(bus.burst_cnt), 32'd2);

      // FIFO runs dry for 5 cycles after word 10.
      push_words(40);
      r0 = total_reqs;
      wait_start("stall_start", 3);
      k = 0;
      while (reqs_in_burst != 10 && k < 40) begin
         cycle();
         k++;
      end
      chk("stall_reach10", 32'(reqs_in_burst), 32'd10);
      stall = 1'b1;
      drive_inputs();
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("stall_req_low", 32'(last_req), 32'd0);
      end
      stall = 1'b0;
      drive_inputs();
      run(60);
      chk("stall_reqs", 32'(total_reqs - r0), 32'd32);
      chk("stall_cnt", 32'(bus.burst_cnt), 32'd3);

      // Two bursts queued back to back: start pulses at minimum spacing.
      push_words(64);
      n0 = start_q.size();
      k  = 0;
      while (start_q.size() < n0 + 2 && k < 120) begin
         cycle();
         k++;
      end
      chk("b2b_starts", 32'(start_q.size() - n0), 32'd2);
      if (start_q.size() >= 2) chk("b2b_spacing", 32'(start_q[$] - start_q[$-1]), 32'(SPACING));
      run(50);
      chk("b2b_cnt", 32'(bus.burst_cnt), 32'd5);

      // Enable dropped mid-burst: burst finishes, nothing further starts.
      push_words(64);
      r0 = total_reqs;
      wait_start("en_drop_start", 3);
      n0 = start_q.size();
      run(5);
      bus.enable = 1'b0;
      run(150);
      chk("en_drop_reqs", 32'(total_reqs - r0), 32'd32);
      chk("en_drop_nostart", 32'(start_q.size() - n0), 32'd0);
      chk("en_drop_cnt", 32'(bus.burst_cnt), 32'd6);
      chk("en_drop_idle", 32'(bus.busy), 32'd0);

      // Completely full FIFO: usedw wraps to 0 but the burst still starts.
      push_words(FIFO_DEPTH - fifo_q.size());
      bus.enable = 1'b1;
      wait_start("full_start", 2);
      bus.enable = 1'b0;
      run(60);
      chk("full_cnt", 32'(bus.burst_cnt), 32'd7);

      // Reset at word 16 clears outputs immediately and forgets the burst.
      bus.enable = 1'b1;
      wait_start("rst_mid_start", 2);
      k = 0;
      while (reqs_in_burst != 16 && k < 40) begin
         cycle();
         k++;
      end
      chk("rst_mid_reach16", 32'(reqs_in_burst), 32'd16);
      rst_n = 1'b0;
      #1;
      chk_cleared("rst_mid");
      model_reset();
      bus.enable = 1'b0;
      run(3);
      rst_n = 1'b1;
      run(3);
      chk("rst_after_cnt", 32'(bus.burst_cnt), 32'd0);
      chk("rst_after_busy", 32'(bus.busy), 32'd0);

      // Clean restart after reset.
      bus.enable = 1'b1;
      wait_start("restart_start", 3);
      run(50);
      chk("restart_cnt", 32'(bus.burst_cnt), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
